ndma_obi_mem_sub: RTL and testbench

// - OBI subordinate (responder) scratchpad memory. It is the far end of the DMA's

---
 rtl/ndma_obi_mem_sub_pkg.sv | 27 ++
 rtl/ndma_obi_mem_sub_if.sv | 26 ++
 rtl/fifo_v3.sv | 73 +++++++
 rtl/ndma_obi_mem_sub.sv | 128 ++++++++++++
 tb/tb_ndma_obi_mem_sub.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ndma_obi_mem_sub_pkg.sv
// Shared types and constants for the OBI subordinate scratchpad memory.
// The byte-enable merge helper keeps lane handling in one place.
package ndma_obi_mem_sub_pkg;

  localparam int unsigned NDMA_OBI_BE_W = 4;
  localparam int unsigned NDMA_OBI_DW   = 32;
  localparam int unsigned NDMA_OBI_AW   = 32;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } ndma_obi_rsp_t;

  function automatic logic [NDMA_OBI_DW-1:0] ndma_apply_be(
    input logic [NDMA_OBI_DW-1:0]   old_word,
    input logic [NDMA_OBI_DW-1:0]   new_word,
    input logic [NDMA_OBI_BE_W-1:0] be
  );
    logic [NDMA_OBI_DW-1:0] res;
    res = old_word;
    for (int k = 0; k < NDMA_OBI_BE_W; k++) begin
      if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ndma_obi_mem_sub_if.sv
// OBI request/response bundle between a manager and the scratchpad subordinate.
interface ndma_obi_mem_sub_if;
  import ndma_obi_mem_sub_pkg::*;

  logic                     req;
  logic                     gnt;
  logic [NDMA_OBI_AW-1:0]   addr;
  logic                     we;
  logic [NDMA_OBI_BE_W-1:0] be;
  logic [NDMA_OBI_DW-1:0]   wdata;
  logic                     rvalid;
  logic                     rready;
  logic [NDMA_OBI_DW-1:0]   rdata;
  logic                     err;

  modport master (
    output req, addr, we, be, wdata, rready,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata, rready,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/fifo_v3.sv
// Synchronous FIFO with registered head; a push is also taken when full if a
// pop happens in the same cycle.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter type         dtype      = logic [DATA_WIDTH-1:0],
  localparam int unsigned PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW      = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            testmode_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] usage_o,
  input  dtype            data_i,
  input  logic            push_i,
  output dtype            data_o,
  input  logic            pop_i
);

  dtype            storage_q [DEPTH];
  dtype            storage_d [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] usage_q, usage_d;
  logic            do_push, do_pop;
  logic            unused_testmode;

  assign unused_testmode = testmode_i;

  assign full_o  = (usage_q == CntW'(DEPTH));
  assign empty_o = (usage_q == '0);
  assign usage_o = usage_q;
  assign data_o  = storage_q[rd_ptr_q];

  always_comb begin
    storage_d = storage_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    do_pop    = pop_i && !empty_o;
    do_push   = push_i && (!full_o || do_pop);
    if (do_push) begin
      storage_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    usage_d = usage_q + CntW'(do_push) - CntW'(do_pop);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      usage_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
      for (int i = 0; i < DEPTH; i++) storage_q[i] <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      usage_q   <= usage_d;
      storage_q <= storage_d;
    end
  end

endmodule

// File: rtl/ndma_obi_mem_sub.sv
// OBI subordinate scratchpad: credit-limited request acceptance, fixed-latency
// response pipeline and an in-order response FIFO honouring rready back-pressure.
module ndma_obi_mem_sub
  import ndma_obi_mem_sub_pkg::*;
#(
  parameter int unsigned NumWords       = 1024,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 4,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000
) (
  input logic               clk_i,
  input logic               rst_ni,
  ndma_obi_mem_sub_if.slave obi
);

  localparam int unsigned IdxW = $clog2(NumWords);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [CntW-1:0] count_q, count_d;
  logic            accept, rsp_pop, in_range;
  logic [31:0]     byte_off, word_off;
  logic [IdxW-1:0] idx;
  ndma_obi_rsp_t   acc_rsp, push_rsp, fifo_head;
  logic            push_valid, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_usage;
  logic [31:0]     mem_q [NumWords];

  // gnt is held low during reset even though the count already reads zero.
  assign obi.gnt = rst_ni && (count_q < CntW'(MaxOutstanding));
  assign accept  = obi.req && obi.gnt;
  assign rsp_pop = obi.rvalid && obi.rready;

  always_comb begin
    byte_off      = obi.addr - BaseAddr;
    word_off      = byte_off >> 2;
    in_range      = (obi.addr >= BaseAddr) && (word_off < NumWords);
    idx           = word_off[IdxW-1:0];
    acc_rsp       = '0;
    acc_rsp.err   = !in_range;
    if (in_range && !obi.we) acc_rsp.rdata = mem_q[idx];
  end

  always_comb begin
    count_d = count_q;
    case ({accept, rsp_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  // Contents survive reset; only accepted in-range writes touch the array.
  always_ff @(posedge clk_i) begin
    if (accept && obi.we && in_range) begin
      mem_q[idx] <= ndma_apply_be(mem_q[idx], obi.wdata, obi.be);
    end
  end

  // The FIFO register itself is the final latency stage, so only Latency-1
  // extra stages sit in front of it.
  if (Latency == 1) begin : g_direct
    assign push_valid = accept;
    assign push_rsp   = acc_rsp;
  end else begin : g_pipe
    localparam int unsigned Depth = Latency - 1;

    logic [Depth-1:0] valid_q, valid_d;
    ndma_obi_rsp_t    rsp_q [Depth];
    ndma_obi_rsp_t    rsp_d [Depth];

    always_comb begin
      valid_d[0] = accept;
      rsp_d[0]   = acc_rsp;
      for (int i = 1; i < Depth; i++) begin
        valid_d[i] = valid_q[i-1];
        rsp_d[i]   = rsp_q[i-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= '0;
        for (int i = 0; i < Depth; i++) rsp_q[i] <= '0;
      end else begin
        valid_q <= valid_d;
        rsp_q   <= rsp_d;
      end
    end

    assign push_valid = valid_q[Depth-1];
    assign push_rsp   = rsp_q[Depth-1];
  end

  fifo_v3 #(
    .DEPTH (MaxOutstanding),
    .dtype (ndma_obi_rsp_t)
  ) i_rsp_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .usage_o    (fifo_usage),
    .data_i     (push_rsp),
    .push_i     (push_valid),
    .data_o     (fifo_head),
    .pop_i      (rsp_pop)
  );

  assign obi.rvalid = !fifo_empty;
  assign obi.rdata  = fifo_empty ? '0   : fifo_head.rdata;
  assign obi.err    = fifo_empty ? 1'b0 : fifo_head.err;

  // The credit limit is what keeps the response FIFO from overflowing.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_valid && fifo_full && !rsp_pop));
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CntW'(MaxOutstanding));
  a_queued_le_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_usage <= count_q);

endmodule

// File: tb/tb_ndma_obi_mem_sub.sv
// Directed bench for the OBI scratchpad: one instance with Latency=1 for access
// semantics, back-pressure and reset, one with Latency=3 for pipelined streaming.
module tb_ndma_obi_mem_sub;
  import ndma_obi_mem_sub_pkg::*;

  localparam logic [31:0] BASE_B = 32'h0000_4000;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  always #5 clk_i = ~clk_i;

  ndma_obi_mem_sub_if bus_a ();
  ndma_obi_mem_sub_if bus_b ();

  ndma_obi_mem_sub #(
    .NumWords(1024), .Latency(1), .MaxOutstanding(4), .BaseAddr(32'h0)
  ) dut_a (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .obi   (bus_a)
  );

  ndma_obi_mem_sub #(
    .NumWords(1024), .Latency(3), .MaxOutstanding(4), .BaseAddr(BASE_B)
  ) dut_b (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .obi   (bus_b)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One access on dut_a with rready high; response must show the cycle after accept.
  task automatic applyStimulus(input vec_t v, input int n);
    int waited;
    @(negedge clk_i);
    bus_a.req    = 1'b1;
    bus_a.we     = v.we;
    bus_a.addr   = v.addr;
    bus_a.be     = v.be;
    bus_a.wdata  = v.wdata;
    bus_a.rready = 1'b1;
    waited = 0;
    while (!bus_a.gnt && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput($sformatf("vec%0d_gnt", n), 32'(bus_a.gnt), 32'd1);
    @(negedge clk_i);
    bus_a.req = 1'b0;
    checkOutput($sformatf("vec%0d_rvalid", n), 32'(bus_a.rvalid), 32'd1);
    checkOutput($sformatf("vec%0d_rdata", n), bus_a.rdata, v.exp_rdata);
    checkOutput($sformatf("vec%0d_err", n), 32'(bus_a.err), 32'(v.exp_err));
  endtask

  function automatic logic [31:0] b_data(input int i);
    return 32'hB000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] out_addr [4];
    logic [31:0] out_data [4];
    int          accepts;
    logic        stale;
    logic        gnt_dropped;

    vecs[0]  = '{1'b1, 32'h0000_0008, 4'hF, 32'hDEAD_BEEF, 32'h0,          1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0008, 4'hF, 32'h0,         32'hDEAD_BEEF,  1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 4'hF, 32'h1122_3344, 32'h0,          1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0010, 4'h5, 32'hAABB_CCDD, 32'h0,          1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'h11BB_33DD,  1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0003, 4'hF, 32'h0102_0304, 32'h0,          1'b0};
    vecs[6]  = '{1'b0, 32'h0000_1000, 4'hF, 32'h0,         32'h0,          1'b1};
    vecs[7]  = '{1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 32'h0,          1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'h0102_0304,  1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0FFC, 4'hF, 32'hCAFE_F00D, 32'h0,          1'b0};
    vecs[10] = '{1'b0, 32'h0000_0FFE, 4'hF, 32'h0,         32'hCAFE_F00D,  1'b0};
    vecs[11] = '{1'b1, 32'h0000_0008, 4'h0, 32'h0,         32'h0,          1'b0};
    vecs[12] = '{1'b0, 32'h0000_0008, 4'hF, 32'h0,         32'hDEAD_BEEF,  1'b0};
    vecs[13] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0,         32'h0,          1'b1};

    out_addr = '{32'h8, 32'h10, 32'hFFC, 32'h0};
    out_data = '{32'hDEAD_BEEF, 32'h11BB_33DD, 32'hCAFE_F00D, 32'h0102_0304};

    bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.be = '0;
    bus_a.wdata = '0; bus_a.rready = 1'b1;
    bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.addr = '0; bus_b.be = '0;
    bus_b.wdata = '0; bus_b.rready = 1'b1;

    repeat (2) @(negedge clk_i);
    checkOutput("reset_gnt_a", 32'(bus_a.gnt), 32'd0);
    checkOutput("reset_rvalid_a", 32'(bus_a.rvalid), 32'd0);
    checkOutput("reset_rdata_a", bus_a.rdata, 32'd0);
    checkOutput("reset_err_a", 32'(bus_a.err), 32'd0);
    checkOutput("reset_gnt_b", 32'(bus_b.gnt), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("post_reset_gnt_a", 32'(bus_a.gnt), 32'd1);
    checkOutput("post_reset_rvalid_a", 32'(bus_a.rvalid), 32'd0);

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

    // Credit exhaustion with rready low, then drain in order.
    @(negedge clk_i);
    bus_a.rready = 1'b0;
    bus_a.req    = 1'b1;
    bus_a.we     = 1'b0;
    bus_a.addr   = out_addr[0];
    accepts      = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus_a.gnt) accepts++;
      @(negedge clk_i);
      if (accepts < 4) bus_a.addr = out_addr[accepts];
    end
    checkOutput("stall_accepts", 32'(accepts), 32'd4);
    checkOutput("stall_gnt", 32'(bus_a.gnt), 32'd0);
    checkOutput("stall_rvalid", 32'(bus_a.rvalid), 32'd1);
    checkOutput("stall_head_rdata", bus_a.rdata, out_data[0]);
    bus_a.req    = 1'b0;
    bus_a.rready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk_i);
      if (k == 1) checkOutput("gnt_after_first_pop", 32'(bus_a.gnt), 32'd1);
      checkOutput($sformatf("drain%0d_rvalid", k), 32'(bus_a.rvalid), 32'd1);
      checkOutput($sformatf("drain%0d_rdata", k), bus_a.rdata, out_data[k]);
    end
    @(negedge clk_i);
    checkOutput("drain_done_rvalid", 32'(bus_a.rvalid), 32'd0);

    // Latency=3 streaming on dut_b: fill memory, then 16 back-to-back reads.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      bus_b.req   = 1'b1;
      bus_b.we    = 1'b1;
      bus_b.be    = 4'hF;
      bus_b.addr  = BASE_B + 32'(4 * i);
      bus_b.wdata = b_data(i);
    end
    @(negedge clk_i);
    bus_b.req = 1'b0;
    repeat (6) @(negedge clk_i);
    gnt_dropped = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (n < 16 && !bus_b.gnt) gnt_dropped = 1'b1;
      checkOutput($sformatf("stream%0d_rvalid", n), 32'(bus_b.rvalid),
                  32'((n >= 3) && (n < 19)));
      if (n >= 3 && n < 19)
        checkOutput($sformatf("stream%0d_rdata", n), bus_b.rdata, b_data(n - 3));
      bus_b.req  = (n < 16);
      bus_b.we   = 1'b0;
      bus_b.addr = BASE_B + 32'(4 * n);
    end
    checkOutput("stream_gnt_dropped", 32'(gnt_dropped), 32'd0);

    // Below-base address on dut_b: error with exact 3-cycle latency.
    @(negedge clk_i);
    bus_b.req  = 1'b1;
    bus_b.addr = BASE_B - 32'd4;
    @(negedge clk_i);
    bus_b.req = 1'b0;
    @(negedge clk_i);
    checkOutput("below_base_early_rvalid", 32'(bus_b.rvalid), 32'd0);
    @(negedge clk_i);
    checkOutput("below_base_rvalid", 32'(bus_b.rvalid), 32'd1);
    checkOutput("below_base_err", 32'(bus_b.err), 32'd1);
    checkOutput("below_base_rdata", bus_b.rdata, 32'd0);

    // Reset with three reads outstanding on dut_a.
    @(negedge clk_i);
    bus_a.rready = 1'b0;
    bus_a.req    = 1'b1;
    bus_a.we     = 1'b0;
    bus_a.addr   = 32'h8;
    repeat (3) @(negedge clk_i);
    bus_a.req = 1'b0;
    rst_ni    = 1'b0;
    #1;
    checkOutput("mid_reset_rvalid", 32'(bus_a.rvalid), 32'd0);
    checkOutput("mid_reset_gnt", 32'(bus_a.gnt), 32'd0);
    @(negedge clk_i);
    checkOutput("mid_reset_rvalid_hold", 32'(bus_a.rvalid), 32'd0);
    checkOutput("mid_reset_gnt_b", 32'(bus_b.gnt), 32'd0);
    rst_ni       = 1'b1;
    bus_a.rready = 1'b1;
    @(negedge clk_i);
    checkOutput("after_reset_gnt", 32'(bus_a.gnt), 32'd1);
    stale = 1'b0;
    repeat (5) begin
      if (bus_a.rvalid) stale = 1'b1;
      @(negedge clk_i);
    end
    checkOutput("no_stale_response", 32'(stale), 32'd0);
    bus_a.rready = 1'b0;
    bus_a.req    = 1'b1;
    accepts      = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus_a.gnt) accepts++;
      @(negedge clk_i);
    end
    checkOutput("after_reset_credits", 32'(accepts), 32'd4);
    bus_a.req    = 1'b0;
    bus_a.rready = 1'b1;
    repeat (6) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
